// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART: parity modes, FSM states,
// data-width decode and parity generation.
package uart_pkg;
    localparam int PAR_W = 8;   // widest word parity_calc() walks over

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    function automatic logic [3:0] nbits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

    function automatic logic parity_on(input parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic parity_calc(input logic [PAR_W-1:0] data, input logic [3:0] width,
                                         input parity_e mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < PAR_W; i++)
            if (4'(i) < width) p = p ^ data[i];
        return (mode == PAR_ODD) ? ~p : p;
    endfunction
endpackage

// File: rtl/uart_cfg_if.sv
// User-side bus of the configurable UART: frame config, tx handshake, rx results.
interface uart_cfg_if #(
    parameter int DBIT_MAX = 8,
    parameter int DVSR_W   = 11
);
    logic [DVSR_W-1:0]   dvsr;
    logic [1:0]          data_bits;
    logic [1:0]          parity_mode;
    logic                stop_bits;
    logic [DBIT_MAX-1:0] din;
    logic                tx_start;
    logic                tx_ready;
    logic                tx_done_tick;
    logic                rx_busy;
    logic                rx_done_tick;
    logic [DBIT_MAX-1:0] dout;
    logic                parity_err;
    logic                frame_err;

    modport master (
        output dvsr, data_bits, parity_mode, stop_bits, din, tx_start,
        input  tx_ready, tx_done_tick, rx_busy, rx_done_tick, dout, parity_err, frame_err
    );
    modport slave (
        input  dvsr, data_bits, parity_mode, stop_bits, din, tx_start,
        output tx_ready, tx_done_tick, rx_busy, rx_done_tick, dout, parity_err, frame_err
    );
endinterface

// File: rtl/uart_frame_rx.sv
// UART receiver: 2-flop synchroniser, start-bit qualification, bit-centre sampling,
// parity and framing checks. Config is captured at the start edge.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int DBIT_MAX = 8,
    parameter int OS       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_tick,
    input  logic                rx,
    input  logic [1:0]          data_bits,
    input  logic [1:0]          parity_mode,
    output logic                rx_busy,
    output logic                rx_done_tick,
    output logic [DBIT_MAX-1:0] dout,
    output logic                parity_err,
    output logic                frame_err
);
    localparam int SC_W  = $clog2(OS);
    localparam int IDX_W = $clog2(DBIT_MAX);

    rx_state_e           state;
    logic                rx_m, rx_s, rx_q;
    logic                fall;
    logic [SC_W-1:0]     sc;
    logic [3:0]          n, nb;
    logic [DBIT_MAX-1:0] data;
    parity_e             par;
    logic                pbit;
    logic                mid_end, bit_end;

    assign fall    = rx_q & ~rx_s;
    assign mid_end = (sc == SC_W'(OS/2 - 1));
    assign bit_end = (sc == SC_W'(OS - 1));
    assign rx_busy = (state != RX_IDLE) | rx_done_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RX_IDLE;
            sc           <= '0;
            n            <= '0;
            nb           <= 4'd8;
            data         <= '0;
            par          <= PAR_NONE;
            pbit         <= 1'b0;
            rx_done_tick <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                RX_IDLE: if (fall) begin
                    nb    <= nbits(data_bits);
                    par   <= parity_e'(parity_mode);
                    sc    <= '0;
                    n     <= '0;
                    data  <= '0;
                    state <= RX_START;
                end
                // line high again at mid start bit means it was a glitch
                RX_START: if (s_tick) begin
                    if (mid_end) begin
                        sc    <= '0;
                        state <= rx_s ? RX_IDLE : RX_DATA;
                    end else sc <= sc + 1'b1;
                end
                RX_DATA: if (s_tick) begin
                    if (bit_end) begin
                        sc                 <= '0;
                        data[n[IDX_W-1:0]] <= rx_s;
                        n                  <= n + 1'b1;
                        if (n == nb - 4'd1) state <= parity_on(par) ? RX_PARITY : RX_STOP;
                    end else sc <= sc + 1'b1;
                end
                RX_PARITY: if (s_tick) begin
                    if (bit_end) begin
                        sc    <= '0;
                        pbit  <= rx_s;
                        state <= RX_STOP;
                    end else sc <= sc + 1'b1;
                end
                RX_STOP: if (s_tick) begin
                    if (bit_end) begin
                        sc           <= '0;
                        rx_done_tick <= 1'b1;
                        dout         <= data;
                        frame_err    <= ~rx_s;
                        parity_err   <= parity_on(par) &&
                                        (pbit != parity_calc(PAR_W'(data), nb, par));
                        state        <= RX_IDLE;
                    end else sc <= sc + 1'b1;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_cfg.sv
// Runtime-configurable UART: baud tick generator and transmitter inline,
// receiver in uart_frame_rx, both driven by the same oversampling tick.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int DBIT_MAX = 8,
    parameter int OS       = 16,
    parameter int DVSR_W   = 11
) (
    input  logic       clk,
    input  logic       rst,
    uart_cfg_if.slave  bus,
    output logic       tx,
    input  logic       rx
);
    localparam int SC_W = $clog2(2 * OS);

    logic [DVSR_W-1:0] cnt;
    logic              s_tick;

    // >= rather than == so a lowered dvsr wraps immediately
    assign s_tick = (cnt >= bus.dvsr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= s_tick ? '0 : cnt + 1'b1;
    end

    tx_state_e           tx_state;
    logic [SC_W-1:0]     tx_sc;
    logic [3:0]          tx_n, tx_nb;
    logic [DBIT_MAX-1:0] tx_sh;
    parity_e             tx_par;
    logic                tx_stop2, tx_pbit;
    logic                bit_end, stop_end;

    assign bit_end          = (tx_sc == SC_W'(OS - 1));
    assign stop_end         = (tx_sc == (tx_stop2 ? SC_W'(2*OS - 1) : SC_W'(OS - 1)));
    assign bus.tx_done_tick = (tx_state == TX_STOP) && s_tick && stop_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state     <= TX_IDLE;
            tx_sc        <= '0;
            tx_n         <= '0;
            tx_nb        <= 4'd8;
            tx_sh        <= '0;
            tx_par       <= PAR_NONE;
            tx_stop2     <= 1'b0;
            tx_pbit      <= 1'b0;
            tx           <= 1'b1;
            bus.tx_ready <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: if (bus.tx_start) begin
                    tx_nb        <= nbits(bus.data_bits);
                    tx_par       <= parity_e'(bus.parity_mode);
                    tx_stop2     <= bus.stop_bits;
                    tx_pbit      <= parity_calc(PAR_W'(bus.din), nbits(bus.data_bits),
                                                parity_e'(bus.parity_mode));
                    tx_sh        <= bus.din;
                    tx_sc        <= '0;
                    tx_n         <= '0;
                    tx           <= 1'b0;
                    bus.tx_ready <= 1'b0;
                    tx_state     <= TX_START;
                end
                TX_START: if (s_tick) begin
                    if (bit_end) begin
                        tx_sc    <= '0;
                        tx       <= tx_sh[0];
                        tx_state <= TX_DATA;
                    end else tx_sc <= tx_sc + 1'b1;
                end
                TX_DATA: if (s_tick) begin
                    if (bit_end) begin
                        tx_sc <= '0;
                        tx_sh <= tx_sh >> 1;
                        tx_n  <= tx_n + 1'b1;
                        if (tx_n == tx_nb - 4'd1) begin
                            tx       <= parity_on(tx_par) ? tx_pbit : 1'b1;
                            tx_state <= parity_on(tx_par) ? TX_PARITY : TX_STOP;
                        end else tx <= tx_sh[1];
                    end else tx_sc <= tx_sc + 1'b1;
                end
                TX_PARITY: if (s_tick) begin
                    if (bit_end) begin
                        tx_sc    <= '0;
                        tx       <= 1'b1;
                        tx_state <= TX_STOP;
                    end else tx_sc <= tx_sc + 1'b1;
                end
                TX_STOP: if (s_tick) begin
                    if (stop_end) begin
                        tx_sc        <= '0;
                        bus.tx_ready <= 1'b1;
                        tx_state     <= TX_IDLE;
                    end else tx_sc <= tx_sc + 1'b1;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    uart_frame_rx #(.DBIT_MAX(DBIT_MAX), .OS(OS)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .s_tick       (s_tick),
        .rx           (rx),
        .data_bits    (bus.data_bits),
        .parity_mode  (bus.parity_mode),
        .rx_busy      (bus.rx_busy),
        .rx_done_tick (bus.rx_done_tick),
        .dout         (bus.dout),
        .parity_err   (bus.parity_err),
        .frame_err    (bus.frame_err)
    );
endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: loopback and bench-driven rx frames, received frames
// checked against a scoreboard of expected {dout, parity_err, frame_err}.
module tb_uart_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, rx, rx_drv, loop;

    always #5 clk = ~clk;

    uart_cfg_if #(.DBIT_MAX(8), .DVSR_W(11)) bus ();
    assign rx = loop ? tx : rx_drv;

    uart_cfg #(.DBIT_MAX(8), .OS(16), .DVSR_W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx),
        .rx  (rx)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   rx_cnt = 0;

    always @(negedge clk) begin
        if (bus.rx_done_tick) begin
            rx_cnt++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected: dout=%h pe=%b fe=%b with nothing expected",
                         bus.dout, bus.parity_err, bus.frame_err);
            end else begin
                mon_e = q.pop_front();
                if ({bus.dout, bus.parity_err, bus.frame_err} !== mon_e) begin
                    bad++;
                    $display("FAIL rx_frame: got dout=%h pe=%b fe=%b want dout=%h pe=%b fe=%b",
                             bus.dout, bus.parity_err, bus.frame_err, mon_e.d, mon_e.pe, mon_e.fe);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Starts a frame at the current negedge; returns cycles from acceptance to tx_done_tick.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pm,
                              input logic sb, input int samp_at, output logic samp,
                              output logic r1, output logic t1, output int k);
        int w;
        w = 0;
        while (bus.tx_ready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        bus.din = d; bus.data_bits = db; bus.parity_mode = pm; bus.stop_bits = sb;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        r1 = bus.tx_ready;
        t1 = tx;
        samp = 1'bx;
        k = -1;
        for (int c = 1; c <= 2000; c++) begin
            if (c == samp_at) samp = tx;
            if (bus.tx_done_tick === 1'b1) begin
                k = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_sb(input string name);
        int w;
        w = 0;
        while (q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d expected rx frames never arrived", name, q.size());
            q.delete();
        end
    endtask

    task automatic drive_rx(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            repeat (64) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({tx, bus.tx_ready, bus.tx_done_tick} !== 3'b110) begin
            bad++;
            $display("FAIL reset_tx: got tx/ready/done=%b want 110", {tx, bus.tx_ready, bus.tx_done_tick});
        end
        total++;
        if ({bus.rx_busy, bus.rx_done_tick, bus.parity_err, bus.frame_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_rx_flags: got %b want 0000",
                     {bus.rx_busy, bus.rx_done_tick, bus.parity_err, bus.frame_err});
        end
        total++;
        if (bus.dout !== 8'h00) begin
            bad++;
            $display("FAIL reset_dout: got %h want 00", bus.dout);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_8n1_loop();
        logic s, r1, t1;
        int k;
        loop = 1'b1;
        q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
        send_frame(8'hA5, 2'd3, 2'b00, 1'b0, 0, s, r1, t1, k);
        total++;
        if ({r1, t1} !== 2'b00) begin
            bad++;
            $display("FAIL 8n1_accept: got ready/tx=%b want 00", {r1, t1});
        end
        total++;
        if (k < 637 || k > 640) begin
            bad++;
            $display("FAIL 8n1_len: got %0d cycles want 637..640", k);
        end
        @(negedge clk);
        total++;
        if (bus.tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL 8n1_ready_after: got %b want 1", bus.tx_ready);
        end
        wait_sb("8n1_rx");
    endtask

    task automatic test_back_to_back();
        logic s, r1, t1;
        int k;
        q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
        send_frame(8'h5A, 2'd3, 2'b01, 1'b1, 608, s, r1, t1, k);
        total++;
        if (s !== 1'b0) begin
            bad++;
            $display("FAIL 8e2_parity_bit: got %b want 0", s);
        end
        total++;
        if (k < 765 || k > 768) begin
            bad++;
            $display("FAIL 8e2_len: got %0d cycles want 765..768", k);
        end
        @(negedge clk);
        total++;
        if (bus.tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: got %b want 1", bus.tx_ready);
        end
        q.push_back('{d: 8'h96, pe: 1'b0, fe: 1'b0});
        send_frame(8'h96, 2'd3, 2'b00, 1'b0, 0, s, r1, t1, k);
        total++;
        if ({r1, t1} !== 2'b00 || k < 637 || k > 640) begin
            bad++;
            $display("FAIL b2b_accept: got ready/tx=%b len=%0d want 00 637..640", {r1, t1}, k);
        end
        wait_sb("b2b_rx");
    endtask

    task automatic test_widths();
        logic s, r1, t1;
        int k;
        q.push_back('{d: 8'h41, pe: 1'b0, fe: 1'b0});
        send_frame(8'hC1, 2'd2, 2'b10, 1'b0, 544, s, r1, t1, k);
        total++;
        if (s !== 1'b1 || k < 637 || k > 640) begin
            bad++;
            $display("FAIL 7o1_frame: got parity=%b len=%0d want 1 637..640", s, k);
        end
        @(negedge clk);
        q.push_back('{d: 8'h1F, pe: 1'b0, fe: 1'b0});
        send_frame(8'hFF, 2'd0, 2'b00, 1'b0, 0, s, r1, t1, k);
        total++;
        if (k < 445 || k > 448) begin
            bad++;
            $display("FAIL 5n1_len: got %0d cycles want 445..448", k);
        end
        wait_sb("widths_rx");
    endtask

    task automatic test_rx_errors();
        int c0;
        loop = 1'b0;
        rx_drv = 1'b1;
        bus.data_bits = 2'd3; bus.parity_mode = 2'b01; bus.stop_bits = 1'b0;
        repeat (64) @(negedge clk);
        c0 = rx_cnt;
        q.push_back('{d: 8'h03, pe: 1'b1, fe: 1'b0});
        drive_rx(12'b011000000110, 11);
        repeat (64) @(negedge clk);
        q.push_back('{d: 8'h03, pe: 1'b1, fe: 1'b1});
        drive_rx(12'b001000000110, 11);
        repeat (64) @(negedge clk);
        wait_sb("rx_err_frames");
        total++;
        if (rx_cnt - c0 !== 2) begin
            bad++;
            $display("FAIL rx_err_pulses: got %0d want 2", rx_cnt - c0);
        end
    endtask

    task automatic test_glitch();
        int c0;
        logic busy_mid;
        c0 = rx_cnt;
        rx_drv = 1'b0;
        repeat (8) @(negedge clk);
        busy_mid = bus.rx_busy;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (100) @(negedge clk);
        total++;
        if ({busy_mid, bus.rx_busy} !== 2'b10 || rx_cnt != c0) begin
            bad++;
            $display("FAIL glitch_busy: got busy mid/end=%b pulses=%0d want 10 0",
                     {busy_mid, bus.rx_busy}, rx_cnt - c0);
        end
        total++;
        if ({bus.dout, bus.parity_err, bus.frame_err} !== {8'h03, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL glitch_flags: got dout=%h pe=%b fe=%b want 03 1 1",
                     bus.dout, bus.parity_err, bus.frame_err);
        end
    endtask

    task automatic test_break();
        int c0;
        bus.data_bits = 2'd3; bus.parity_mode = 2'b00; bus.stop_bits = 1'b0;
        c0 = rx_cnt;
        q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
        rx_drv = 1'b0;
        repeat (20 * 64) @(negedge clk);
        total++;
        if (bus.rx_busy !== 1'b0 || rx_cnt - c0 != 1) begin
            bad++;
            $display("FAIL break_low: got busy=%b pulses=%0d want 0 1", bus.rx_busy, rx_cnt - c0);
        end
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        total++;
        if (rx_cnt - c0 != 1) begin
            bad++;
            $display("FAIL break_retrigger: got %0d pulses want 1", rx_cnt - c0);
        end
        wait_sb("break_rx");
    endtask

    task automatic test_reset_mid();
        logic s, r1, t1, busy_pre;
        int k;
        loop = 1'b1;
        bus.din = 8'h77; bus.data_bits = 2'd3; bus.parity_mode = 2'b00; bus.stop_bits = 1'b0;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (300) @(negedge clk);
        busy_pre = bus.rx_busy;
        rst = 1'b1;
        #1;
        total++;
        if ({busy_pre, tx, bus.tx_ready, bus.rx_busy} !== 4'b1110) begin
            bad++;
            $display("FAIL rst_mid: got busy_pre/tx/ready/busy=%b want 1110",
                     {busy_pre, tx, bus.tx_ready, bus.rx_busy});
        end
        total++;
        if ({bus.dout, bus.frame_err} !== 9'h000) begin
            bad++;
            $display("FAIL rst_mid_dout: got dout=%h fe=%b want 00 0", bus.dout, bus.frame_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        q.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
        send_frame(8'h3C, 2'd3, 2'b00, 1'b0, 0, s, r1, t1, k);
        total++;
        if (k < 637 || k > 640) begin
            bad++;
            $display("FAIL rst_recover_len: got %0d cycles want 637..640", k);
        end
        wait_sb("rst_recover_rx");
    endtask

    initial begin
        loop = 1'b0;
        rx_drv = 1'b1;
        bus.dvsr = 11'd3;
        bus.data_bits = 2'd3;
        bus.parity_mode = 2'b00;
        bus.stop_bits = 1'b0;
        bus.din = 8'h00;
        bus.tx_start = 1'b0;
        test_reset();
        test_8n1_loop();
        test_back_to_back();
        test_widths();
        test_rx_errors();
        test_glitch();
        test_break();
        test_reset_mid();
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
